// File: rtl/addripple_n.sv
// Ripple-carry adder, WIDTH bits, no carry in/out: callers zero-extend by one bit to recover the carry.
// Purely combinational; no handshake.
module addripple_n #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        assign o_sum[k] = i_a[k] ^ i_b[k] ^ w_c[k];
        if (k < WIDTH - 1) begin : g_carry
            assign w_c[k+1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
        end
    end

endmodule

// File: rtl/pipeadd_n.sv
// Elastic pipelined adder: NUM_OPS operands, one addition per stage, latency NUM_OPS-1 edges.
// in_ready ripples back combinationally from out_ready; all stages hold when the output stalls.
module pipeadd_n #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_ovf
);

    localparam int DEPTH = NUM_OPS - 1;

    logic [DEPTH-1:0] w_adv;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stg
        // Width of the operands still waiting to be added after this stage.
        localparam int CW = (NUM_OPS - 2 - s) * WIDTH;

        logic             r_vld;
        logic             r_ovf;
        logic [WIDTH-1:0] r_sum;

        logic             w_up_vld;
        logic             w_up_ovf;
        logic             w_up_sat;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH:0]   w_full;
        logic             w_ovf_nxt;

        if (s == 0) begin : g_head
            assign w_up_vld = in_valid;
            assign w_up_ovf = 1'b0;
            assign w_up_sat = in_sat;
            assign w_a      = in_ops[0 +: WIDTH];
            assign w_b      = in_ops[WIDTH +: WIDTH];
        end else begin : g_body
            assign w_up_vld = g_stg[s-1].r_vld;
            assign w_up_ovf = g_stg[s-1].r_ovf;
            assign w_up_sat = g_stg[s-1].g_cry.r_sat;
            assign w_a      = g_stg[s-1].r_sum;
            assign w_b      = g_stg[s-1].g_cry.r_ops[WIDTH-1:0];
        end

        if (s == DEPTH - 1) begin : g_tail
            assign w_adv[s] = !r_vld || out_ready;
        end else begin : g_mid
            assign w_adv[s] = !r_vld || w_adv[s+1];
        end

        addripple_n #(
            .WIDTH (WIDTH + 1)
        ) u_add (
            .i_a   ({1'b0, w_a}),
            .i_b   ({1'b0, w_b}),
            .o_sum (w_full)
        );

        assign w_ovf_nxt = w_up_ovf | w_full[WIDTH];

        // Data only loads with a valid bundle, so idle-input X never reaches the registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_ovf <= 1'b0;
                r_sum <= '0;
            end else if (w_adv[s]) begin
                r_vld <= w_up_vld;
                if (w_up_vld) begin
                    r_ovf <= w_ovf_nxt;
                    r_sum <= (w_up_sat && w_ovf_nxt) ? '1 : w_full[WIDTH-1:0];
                end
            end
        end

        if (CW > 0) begin : g_cry
            logic          r_sat;
            logic [CW-1:0] r_ops;
            logic [CW-1:0] w_ops_nxt;

            if (s == 0) begin : g_src_in
                assign w_ops_nxt = in_ops[NUM_OPS*WIDTH-1 : 2*WIDTH];
            end else begin : g_src_prev
                assign w_ops_nxt = g_stg[s-1].g_cry.r_ops[CW+WIDTH-1 : WIDTH];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sat <= 1'b0;
                    r_ops <= '0;
                end else if (w_adv[s] && w_up_vld) begin
                    r_sat <= w_up_sat;
                    r_ops <= w_ops_nxt;
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = g_stg[DEPTH-1].r_vld;
    assign out_sum   = g_stg[DEPTH-1].r_sum;
    assign out_ovf   = g_stg[DEPTH-1].r_ovf;

endmodule
